// File: rtl/motion_sequencer.sv
// Motion sequencer: plays back three-axis servo waypoints from ROM with a
// 1-LSB-per-tick ramp and a dwell at each waypoint, or passes live
// accelerometer positions straight through when playback is not selected.
module motion_sequencer #(
  parameter int unsigned            ADDR_WIDTH  = 8,
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            RAMP_DIV    = 50000,
  parameter int unsigned            DWELL_TICKS = 500,
  parameter logic [DATA_WIDTH-1:0]  END_CODE    = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] live_x,
  input  logic [DATA_WIDTH-1:0] live_y,
  input  logic [DATA_WIDTH-1:0] live_z,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data_x,
  input  logic [DATA_WIDTH-1:0] rom_data_y,
  input  logic [DATA_WIDTH-1:0] rom_data_z,
  output logic [DATA_WIDTH-1:0] pos_x,
  output logic [DATA_WIDTH-1:0] pos_y,
  output logic [DATA_WIDTH-1:0] pos_z,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned TICK_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DWELL_W = (DWELL_TICKS > 0) ? $clog2(DWELL_TICKS + 1) : 1;
  localparam logic [TICK_W-1:0]     TICK_LAST  = TICK_W'(RAMP_DIV - 1);
  localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
  localparam logic [DATA_WIDTH-1:0] CENTRE     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_RAMP,
    S_DWELL,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [DWELL_W-1:0]    r_dwell_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] r_pos_x, r_pos_y, r_pos_z;
  logic [DATA_WIDTH-1:0] r_tgt_x, r_tgt_y, r_tgt_z;
  logic                  r_busy, r_done;
  logic                  w_tick, w_is_end, w_at_tgt, w_busy_state, w_abort;
  logic                  w_load_tgt, w_step, w_dwell_clr;

  // One LSB toward the target; never passes it, so no wrap at either rail.
  function automatic logic [DATA_WIDTH-1:0] f_step(input logic [DATA_WIDTH-1:0] p,
                                                   input logic [DATA_WIDTH-1:0] t);
    if (p < t)      return p + 1'b1;
    else if (p > t) return p - 1'b1;
    else            return p;
  endfunction

  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_is_end     = (rom_data_x == END_CODE) && (rom_data_y == END_CODE) &&
                        (rom_data_z == END_CODE);
  assign w_at_tgt     = (r_pos_x == r_tgt_x) && (r_pos_y == r_tgt_y) && (r_pos_z == r_tgt_z);
  assign w_busy_state = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_abort      = stop || !mode;

  // Free-running ramp-tick prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and datapath control decode; abort overrides every busy-state action.
  always_comb begin
    w_next_state = r_state;
    w_addr_next  = r_addr;
    w_load_tgt   = 1'b0;
    w_step       = 1'b0;
    w_dwell_clr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && mode && !stop) begin
          w_next_state = S_FETCH;
          w_addr_next  = '0;
        end
      end
      S_FETCH: w_next_state = S_LATCH;
      S_LATCH: begin
        if (w_is_end) begin
          if (loop_en) begin
            w_next_state = S_FETCH;
            w_addr_next  = '0;
          end else begin
            w_next_state = S_DONE;
          end
        end else begin
          w_load_tgt   = 1'b1;
          w_next_state = S_RAMP;
        end
      end
      S_RAMP: begin
        if (w_at_tgt) begin
          w_next_state = S_DWELL;
          w_dwell_clr  = 1'b1;
        end else if (w_tick) begin
          w_step = 1'b1;
        end
      end
      S_DWELL: begin
        if (w_tick && (r_dwell_cnt == DWELL_LAST)) begin
          w_next_state = S_FETCH;
          w_addr_next  = r_addr + 1'b1;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (w_busy_state && w_abort) begin
      w_next_state = S_IDLE;
      w_addr_next  = r_addr;
      w_load_tgt   = 1'b0;
      w_step       = 1'b0;
      w_dwell_clr  = 1'b0;
    end
  end

  // Dwell tick counter, cleared on DWELL entry and advanced on ticks only.
  always_ff @(posedge clk) begin
    if (!rst_n)                            r_dwell_cnt <= '0;
    else if (w_dwell_clr)                  r_dwell_cnt <= '0;
    else if (r_state == S_DWELL && w_tick) r_dwell_cnt <= r_dwell_cnt + 1'b1;
  end

  // Address, targets, positions and status flags; busy/done decode the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_pos_x <= CENTRE;
      r_pos_y <= CENTRE;
      r_pos_z <= CENTRE;
      r_tgt_x <= CENTRE;
      r_tgt_y <= CENTRE;
      r_tgt_z <= CENTRE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_addr <= w_addr_next;
      r_busy <= (w_next_state != S_IDLE) && (w_next_state != S_DONE);
      r_done <= (w_next_state == S_DONE);
      if (w_load_tgt) begin
        r_tgt_x <= rom_data_x;
        r_tgt_y <= rom_data_y;
        r_tgt_z <= rom_data_z;
      end
      if (r_state == S_IDLE && !mode) begin
        r_pos_x <= live_x;
        r_pos_y <= live_y;
        r_pos_z <= live_z;
      end else if (w_step) begin
        r_pos_x <= f_step(r_pos_x, r_tgt_x);
        r_pos_y <= f_step(r_pos_y, r_tgt_y);
        r_pos_z <= f_step(r_pos_z, r_tgt_z);
      end
    end
  end

  assign rom_address = r_addr;
  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign pos_z       = r_pos_z;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_motion_sequencer.sv
// Testbench for motion_sequencer: scoreboard of expected position steps and
// address changes, popped when the outputs move.
module tb_motion_sequencer;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned RD = 4;
  localparam int unsigned DT = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, loop_en, mode;
  logic [DW-1:0] live_x, live_y, live_z;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_data_x, rom_data_y, rom_data_z;
  logic [DW-1:0] pos_x, pos_y, pos_z;
  logic          busy, done;

  motion_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RAMP_DIV   (RD),
    .DWELL_TICKS(DT),
    .END_CODE   (8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .mode       (mode),
    .live_x     (live_x),
    .live_y     (live_y),
    .live_z     (live_z),
    .rom_address(rom_address),
    .rom_data_x (rom_data_x),
    .rom_data_y (rom_data_y),
    .rom_data_z (rom_data_z),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_z      (pos_z),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Servo ROMs: one-cycle registered read.
  logic [DW-1:0] rom_x [256];
  logic [DW-1:0] rom_y [256];
  logic [DW-1:0] rom_z [256];
  always @(posedge clk) begin
    rom_data_x <= rom_x[rom_address];
    rom_data_y <= rom_y[rom_address];
    rom_data_z <= rom_z[rom_address];
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_pos_cyc = -1;
  int addr_chg_cnt = 0;
  int done_cnt = 0;
  bit mon_en = 0;
  bit spacing_en = 0;
  bit dwell_en = 0;
  logic [23:0]   prev_pos;
  logic [AW-1:0] prev_addr;
  logic [23:0]   exp_pos_q [$];
  logic [AW-1:0] exp_addr_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard whenever position or address moves.
  always @(negedge clk) begin
    logic [23:0] cur;
    cur = {pos_x, pos_y, pos_z};
    cyc++;
    if (done === 1'b1) done_cnt++;
    if (mon_en && cur !== prev_pos) begin
      if (exp_pos_q.size() == 0) chk("pos_unexpected", {8'h0, cur}, {8'h0, prev_pos});
      else                       chk("pos_step", {8'h0, cur}, {8'h0, exp_pos_q.pop_front()});
      if (spacing_en && last_pos_cyc >= 0) chk("step_gap", cyc - last_pos_cyc, RD);
      last_pos_cyc = cyc;
    end
    if (mon_en && rom_address !== prev_addr) begin
      addr_chg_cnt++;
      if (exp_addr_q.size() == 0) chk("addr_unexpected", rom_address, prev_addr);
      else                        chk("addr_seq", rom_address, exp_addr_q.pop_front());
      if (dwell_en) begin
        chk("dwell_len", cyc - last_pos_cyc, DT * RD);
        dwell_en = 0;
      end
    end
    prev_pos  = cur;
    prev_addr = rom_address;
  end

  task automatic do_reset();
    mon_en     = 0;
    spacing_en = 0;
    dwell_en   = 0;
    start      = 0;
    stop       = 0;
    rst_n      = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push_program_steps();
    exp_pos_q.push_back({8'h81, 8'h80, 8'h7F});
    exp_pos_q.push_back({8'h82, 8'h80, 8'h7E});
    exp_pos_q.push_back({8'h83, 8'h80, 8'h7E});
  endtask

  initial begin
    bit seen;
    int busy_cnt;
    for (int i = 0; i < 256; i++) begin
      rom_x[i] = 8'h80; rom_y[i] = 8'h80; rom_z[i] = 8'h80;
    end
    rom_x[0] = 8'h83; rom_y[0] = 8'h80; rom_z[0] = 8'h7E;
    rom_x[1] = 8'hFF; rom_y[1] = 8'hFF; rom_z[1] = 8'hFF;
    rst_n = 0; start = 0; stop = 0; loop_en = 0; mode = 1;
    live_x = 8'h00; live_y = 8'h00; live_z = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pos", {8'h0, pos_x, pos_y, pos_z}, 32'h00808080);
    chk("rst_addr", rom_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    @(negedge clk);

    // Live pass-through
    mode = 0; live_x = 8'h10; live_y = 8'h20; live_z = 8'h30;
    @(negedge clk);
    chk("live_pos", {8'h0, pos_x, pos_y, pos_z}, 32'h00102030);
    chk("live_busy", busy, 0);
    live_x = 8'hA5;
    @(negedge clk);
    chk("live_x2", pos_x, 8'hA5);

    // Single program, no loop; also hold in IDLE with mode=1 and start in DONE
    mode = 1; loop_en = 0;
    do_reset();
    mon_en = 1;
    live_x = 8'h55;
    repeat (5) @(negedge clk);
    chk("idle_hold", pos_x, 8'h80);
    push_program_steps();
    exp_addr_q.push_back(8'd1);
    spacing_en = 1; dwell_en = 1; last_pos_cyc = -1; done_cnt = 0;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (done === 1'b1) begin
        seen = 1;
        chk("busy_in_done", busy, 0);
        start = 1;
        @(negedge clk);
        start = 0;
      end else begin
        @(negedge clk);
      end
    end
    chk("wait_done", seen, 1);
    repeat (5) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("idle_after_done", busy, 0);
    chk("pos_q_empty", exp_pos_q.size(), 0);
    chk("addr_q_empty", exp_addr_q.size(), 0);

    // Looping program
    loop_en = 1;
    do_reset();
    mon_en = 1;
    push_program_steps();
    exp_addr_q.push_back(8'd1); exp_addr_q.push_back(8'd0);
    exp_addr_q.push_back(8'd1); exp_addr_q.push_back(8'd0);
    spacing_en = 1; last_pos_cyc = -1; addr_chg_cnt = 0; done_cnt = 0;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (addr_chg_cnt >= 4) seen = 1;
    end
    chk("wait_loop", seen, 1);
    stop = 1;
    @(negedge clk);
    stop = 0;
    repeat (5) @(negedge clk);
    chk("loop_no_done", done_cnt, 0);
    chk("loop_stop_busy", busy, 0);
    chk("loop_addr", rom_address, 0);
    chk("loop_addr_q_empty", exp_addr_q.size(), 0);
    chk("loop_pos_q_empty", exp_pos_q.size(), 0);

    // Stop during RAMP
    loop_en = 0;
    do_reset();
    mon_en = 1;
    exp_pos_q.push_back({8'h81, 8'h80, 8'h7F});
    exp_pos_q.push_back({8'h82, 8'h80, 8'h7E});
    spacing_en = 1; last_pos_cyc = -1;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (pos_x === 8'h82) seen = 1;
    end
    chk("wait_82", seen, 1);
    chk("ramp_busy", busy, 1);
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("stop_busy", busy, 0);
    chk("stop_pos_x", pos_x, 8'h82);
    repeat (10) @(negedge clk);
    chk("stop_hold_x", pos_x, 8'h82);
    chk("stop_q_empty", exp_pos_q.size(), 0);

    // Simultaneous start and stop in IDLE
    do_reset();
    start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("startstop_busy", busy_cnt, 0);
    chk("startstop_addr", rom_address, 0);

    // Mode falling while busy
    do_reset();
    pulse_start();
    chk("fetch_busy", busy, 1);
    mode = 0;
    @(negedge clk);
    chk("modefall_busy", busy, 0);
    mode = 1;

    // Reset during DWELL
    do_reset();
    mon_en = 1;
    push_program_steps();
    exp_pos_q.push_back({8'h80, 8'h80, 8'h80});
    done_cnt = 0;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (exp_pos_q.size() == 1) seen = 1;
    end
    chk("wait_target", seen, 1);
    repeat (3) @(negedge clk);
    chk("dwell_busy", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("dwell_rst_pos", {8'h0, pos_x, pos_y, pos_z}, 32'h00808080);
    chk("dwell_rst_addr", rom_address, 0);
    chk("dwell_rst_done", done, 0);
    chk("dwell_rst_busy", busy, 0);
    rst_n = 1;
    repeat (30) @(negedge clk);
    chk("dwell_rst_no_done", done_cnt, 0);
    chk("dwell_rst_q_empty", exp_pos_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 8: program ROM address width.
- DATA_WIDTH, 8: servo position width.
- RAMP_DIV, 50000: clk cycles per ramp tick (1 ms at 50 MHz).
- DWELL_TICKS, 500: ramp ticks held at each reached waypoint.
- END_CODE, 8'hFF: value marking end of program when present on all three axes.
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
- clk, in, 1: sole clock (MAX10_CLK1_50 at top level).
- rst_n, in, 1: reset, synchronous, active-low.
- start, in, 1: one-cycle pulse; begin playback at address 0.
- stop, in, 1: one-cycle pulse; abort playback.
- loop_en, in, 1: restart at address 0 after END_CODE.
- mode, in, 1: 0 = live pass-through, 1 = ROM playback.
- live_x / live_y / live_z, in, DATA_WIDTH each: live positions (accelerometer path).
- rom_address, out, ADDR_WIDTH: shared address to the three servo ROMs.
- rom_data_x / rom_data_y / rom_data_z, in, DATA_WIDTH each: ROM outputs, valid one cycle after rom_address changes.
- pos_x / pos_y / pos_z, out, DATA_WIDTH each: position to the PWM data inputs.
- busy, out, 1: high in any state other than IDLE and DONE.
- done, out, 1: one-cycle pulse on program end without loop.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, LATCH, RAMP, DWELL and DONE, with the following transitions:
- IDLE to FETCH on start while mode=1.
- FETCH to LATCH after 1 cycle (ROM latency).
- LATCH to DONE on END_CODE if loop_en=0.
- LATCH to FETCH at address 0 on END_CODE if loop_en=1.
- LATCH to RAMP otherwise, loading target_x/y/z.
- RAMP to DWELL when pos equals target on all axes.
- DWELL to FETCH at address+1 after DWELL_TICKS ticks.
- DONE to IDLE after 1 cycle.
REQ-004 A free-running tick counter SHALL count 0..RAMP_DIV-1 and assert tick for one cycle at RAMP_DIV-1.
REQ-005 In RAMP, on each tick, each axis SHALL move 1 LSB toward its target; an axis equal to its target SHALL hold.
REQ-006 Ramp arithmetic SHALL be unsigned with no overshoot and no wrap at 0 or 2^DATA_WIDTH-1.
REQ-007 Entering DWELL SHALL clear the dwell counter; the counter SHALL increment on tick only.
REQ-008 Address increment SHALL wrap from 2^ADDR_WIDTH-1 to 0; wrap SHALL NOT count as program end.
REQ-009 stop, or mode falling to 0, in any busy state SHALL force IDLE next cycle; pos SHALL hold its current value (no snap).
REQ-010 Simultaneous start and stop SHALL resolve to stop.
REQ-011 start while busy SHALL be ignored.
REQ-012 start in DONE SHALL be ignored.
REQ-013 In IDLE with mode=0, pos SHALL register live_x/y/z every cycle (1-cycle latency).
REQ-014 In IDLE with mode=1, pos SHALL hold its value.
REQ-015 busy SHALL be a registered decode of the FSM state.
REQ-016 done SHALL be registered and high only in the cycle the FSM is in DONE.
REQ-017 A target equal to the current pos SHALL pass through RAMP for one cycle, then enter DWELL.

Reset
REQ-018 With rst_n=0 at a clk edge, the block SHALL reset state to IDLE, rom_address to 0, pos_x/y/z to 8'h80 (servo centre), targets to 8'h80, and all counters, busy and done to 0.
REQ-019 Reset mid-operation SHALL abandon the program with no done pulse.
REQ-020 Reset SHALL take priority over start, stop and mode.

Verification (RAMP_DIV=4, DWELL_TICKS=2)
REQ-021 Reset then mode=0, live_x=8'h10 -> pos_x=8'h10 one cycle later; busy=0.
REQ-022 mode=1, ROM[0]=(8'h83,8'h80,8'h7E), ROM[1]=END, start, loop_en=0:
- pos_x steps 80,81,82,83 on successive ticks and pos_z steps 80,7F,7E.
- Dwell lasts 2 ticks; rom_address then reaches 1.
- done pulses once; FSM returns to IDLE.
REQ-023 Same program with loop_en=1 -> rom_address returns to 0 after END and no done pulse occurs.
REQ-024 stop during RAMP with pos_x=8'h82 -> IDLE next cycle; pos_x stays 8'h82; busy=0.
REQ-025 Simultaneous start and stop in IDLE -> FSM remains in IDLE; rom_address=0.
REQ-026 rst_n low during DWELL -> pos_x/y/z=8'h80, rom_address=0, done=0.
